// File: rtl/network_sequencer.sv
// Sequences one bitstream run of a stochastic network: clear, L compute cycles,
// integrate, then capture the network result and pulse done.
module network_sequencer #(
  parameter int unsigned INPUT_SIZE  = 2,
  parameter int unsigned OUTPUT_SIZE = 1,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_LENGTH  = 256,
  localparam int unsigned CNT_W      = $clog2(MAX_LENGTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [CNT_W-1:0]                        len_cfg,
  input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]   data_in,
  input  logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]  net_result,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]   net_in,
  output logic                                    net_rst,
  output logic                                    net_compute,
  output logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0]  data_out,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    aborted,
  output logic [2:0]                              state_out,
  output logic [CNT_W-1:0]                        bit_count
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StClear     = 3'd1,
    StCompute   = 3'd2,
    StIntegrate = 3'd3,
    StDone      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] MaxLen = CNT_W'(MAX_LENGTH);

  state_e                                 state_q, state_d;
  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  net_in_q;
  logic [OUTPUT_SIZE-1:0][DATA_WIDTH-1:0] data_out_q;
  logic [CNT_W-1:0]                       len_q;
  logic [CNT_W-1:0]                       bit_count_q;
  logic                                   aborted_q;

  logic [CNT_W-1:0] eff_len;
  logic [CNT_W-1:0] last_count;
  logic             accept;
  logic             run_abort;

  // Zero or out-of-range lengths fall back to the full bitstream.
  assign eff_len    = ((len_cfg == '0) || (len_cfg > MaxLen)) ? MaxLen : len_cfg;
  assign last_count = len_q - CNT_W'(1);
  assign accept     = (state_q == StIdle) && start && !abort;
  assign run_abort  = abort && ((state_q == StClear) || (state_q == StCompute) ||
                                (state_q == StIntegrate));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (accept) state_d = StClear;
      StClear:     state_d = abort ? StIdle : StCompute;
      StCompute: begin
        if (abort)                           state_d = StIdle;
        else if (bit_count_q == last_count)  state_d = StIntegrate;
      end
      StIntegrate: state_d = abort ? StIdle : StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      net_in_q    <= '0;
      data_out_q  <= '0;
      len_q       <= '0;
      bit_count_q <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        net_in_q    <= data_in;
        len_q       <= eff_len;
        bit_count_q <= '0;
        aborted_q   <= 1'b0;
      end
      if ((state_q == StCompute) && !abort) begin
        bit_count_q <= bit_count_q + CNT_W'(1);
      end
      if ((state_q == StIntegrate) && !abort) begin
        data_out_q <= net_result;
      end
      if (run_abort) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Every output is a register or a pure decode of the state register.
  assign net_in      = net_in_q;
  assign data_out    = data_out_q;
  assign bit_count   = bit_count_q;
  assign aborted     = aborted_q;
  assign state_out   = state_q;
  assign net_rst     = (state_q == StClear);
  assign net_compute = (state_q == StCompute);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

endmodule

// File: doc/network_sequencer.md
NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001 Parameter INPUT_SIZE, default 2: number of network input channels.
REQ-002 Parameter OUTPUT_SIZE, default 1: number of network output channels.
REQ-003 Parameter DATA_WIDTH, default 32: bits per channel value.
REQ-004 Parameter MAX_LENGTH, default 256: maximum bitstream length; CNT_W = $clog2(MAX_LENGTH+1).
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  request a run; sampled only in IDLE.
REQ-008 abort  in  1  cancel a run in progress.
REQ-009 len_cfg  in  CNT_W  requested bitstream length, sampled with start.
REQ-010 data_in  in  [INPUT_SIZE] x DATA_WIDTH  run operands, sampled with start.
REQ-011 net_result  in  [OUTPUT_SIZE] x DATA_WIDTH  network output values.
REQ-012 net_in  out  [INPUT_SIZE] x DATA_WIDTH  latched operands driven to the network.
REQ-013 net_rst  out  1  network clear, active-high.
REQ-014 net_compute  out  1  network advance-one-bit enable.
REQ-015 data_out  out  [OUTPUT_SIZE] x DATA_WIDTH  captured results of the last completed run.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 aborted  out  1  sticky flag: last run was aborted.
REQ-019 state_out  out  3  encoded FSM state: IDLE=0, CLEAR=1, COMPUTE=2, INTEGRATE=3, DONE=4.
REQ-020 bit_count  out  CNT_W  number of compute cycles issued in the current run.

Function
REQ-021 FSM states: IDLE, CLEAR, COMPUTE, INTEGRATE, DONE; outputs are registered or decoded from state only, with no combinational path from start/abort to any output.
REQ-022 IDLE: on start=1 and abort=0, the block latches data_in into net_in, latches effective length L, clears bit_count and aborted, and moves to CLEAR; otherwise it stays in IDLE.
REQ-023 L = MAX_LENGTH when len_cfg is 0 or exceeds MAX_LENGTH; otherwise L = len_cfg.
REQ-024 CLEAR: lasts exactly one cycle with net_rst=1 and net_compute=0, then moves to COMPUTE.
REQ-025 COMPUTE: net_compute=1 on every cycle; bit_count increments by 1 per cycle; after the cycle in which bit_count==L-1 the FSM moves to INTEGRATE, giving exactly L compute cycles.
REQ-026 INTEGRATE: lasts one cycle with net_compute=0; at its closing edge data_out <= net_result and the FSM moves to DONE.
REQ-027 DONE: done=1 for this single cycle, then the FSM returns to IDLE; a start in DONE is ignored.
REQ-028 Latency: with start sampled at edge 0, CLEAR occupies cycle 1, COMPUTE cycles 2..L+1, INTEGRATE cycle L+2, and done is high in cycle L+3.
REQ-029 start while busy is ignored; net_in and L hold stable for the whole run.
REQ-030 abort=1 in CLEAR, COMPUTE or INTEGRATE: the next state is IDLE and aborted <= 1; data_out is not updated and done is not pulsed.
REQ-031 abort=1 in IDLE or DONE has no effect; start and abort both high in IDLE leaves the FSM in IDLE.
REQ-032 bit_count holds its final value after a run until the next accepted start; it never exceeds MAX_LENGTH.
REQ-033 data_out holds its value across aborted runs and idle periods.

Reset
REQ-034 rst=1 at a rising edge forces IDLE, regardless of the current state.
REQ-035 During and after reset, all outputs are 0: net_in, data_out, bit_count, net_rst, net_compute, busy, done, aborted, and state_out.
REQ-036 Reset asserted mid-run discards the run with no done pulse; aborted stays 0.

Verification
REQ-037 Normal run: len_cfg=4, data_in={5,9}, net_result=7 -> net_rst high in cycle 1, net_compute high in cycles 2-5, done in cycle 7, data_out=7, bit_count=4.
REQ-038 Length clamp: len_cfg=0, then len_cfg=300 with MAX_LENGTH=256 -> each run issues exactly 256 compute cycles, and done arrives 259 cycles after start.
REQ-039 Abort: len_cfg=10 with abort pulsed in compute cycle 3 -> IDLE next cycle, aborted=1, no done, data_out unchanged; the next start clears aborted.
REQ-040 Start while busy: a second start pulse during COMPUTE with a different data_in -> ignored, and net_in keeps the first operands.
REQ-041 Reset mid-run: rst during COMPUTE -> all outputs 0 next cycle and state_out=0; a later start runs normally.
REQ-042 Minimum length: len_cfg=1 -> a single net_compute cycle, and done in cycle 4.
